dec5_32_bitmap: RTL and testbench

DEC5_32_BITMAP -- requirements
Module: dec5_32_bitmap

---
 rtl/dec5_32_bitmap.sv | 98 +++++++++
 tb/tb_dec5_32_bitmap.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dec5_32_bitmap.sv
// 5-to-32 decoder that maintains a 32-bit bitmap with set/clear/toggle/clear-all
// commands. It also emits a registered one-hot of each accepted index over a valid/ready handshake.
module dec5_32_bitmap #(
  parameter bit STICKY_ERR = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  in_idx,
  input  logic [1:0]  in_op,
  input  logic        in_v,
  output logic        in_rdy,
  output logic [31:0] out_onehot,
  output logic        out_v,
  input  logic        out_rdy,
  output logic [31:0] map,
  output logic [5:0]  cnt,
  output logic        empty,
  output logic        full,
  output logic        err
);

  typedef enum logic [1:0] {
    OP_SET   = 2'b00,
    OP_CLEAR = 2'b01,
    OP_TOG   = 2'b10,
    OP_CLALL = 2'b11
  } op_t;

  logic        accept;
  logic [31:0] mask;
  logic [31:0] map_next;
  logic        redundant;
  logic [5:0]  cnt_next;

  assign in_rdy = !(out_v && !out_rdy);
  assign accept = in_v && in_rdy;
  assign mask   = 32'd1 << in_idx;

  // Next map and redundancy are judged against the map before this edge, so
  // redundant commands naturally leave the map untouched.
  always_comb begin
    map_next  = map;
    redundant = 1'b0;
    case (op_t'(in_op))
      OP_SET: begin
        redundant = (map & mask) != 32'd0;
        map_next  = map | mask;
      end
      OP_CLEAR: begin
        redundant = (map & mask) == 32'd0;
        map_next  = map & ~mask;
      end
      OP_TOG: begin
        map_next  = map ^ mask;
      end
      default: begin
        redundant = (map == 32'd0);
        map_next  = 32'd0;
      end
    endcase
  end

  always_comb begin
    cnt_next = 6'd0;
    for (int i = 0; i < 32; i++) begin
      cnt_next = cnt_next + {5'd0, map_next[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      map        <= 32'd0;
      cnt        <= 6'd0;
      empty      <= 1'b1;
      full       <= 1'b0;
      out_onehot <= 32'd0;
      out_v      <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (accept) begin
        map        <= map_next;
        cnt        <= cnt_next;
        empty      <= (cnt_next == 6'd0);
        full       <= (cnt_next == 6'd32);
        out_onehot <= (op_t'(in_op) == OP_CLALL) ? 32'd0 : mask;
        out_v      <= 1'b1;
      end else if (out_v && out_rdy) begin
        out_v      <= 1'b0;
      end
      if (STICKY_ERR) begin
        err <= err | (accept && redundant);
      end else begin
        err <= accept && redundant;
      end
    end
  end

endmodule

// File: tb/tb_dec5_32_bitmap.sv
// Self-checking bench for dec5_32_bitmap: directed table, hand sequences and a
// randomized run against a bit-array reference model; sticky and pulse variants.
module tb_dec5_32_bitmap;

  logic        clk;
  logic        rst_n;
  logic [4:0]  in_idx;
  logic [1:0]  in_op;
  logic        in_v;
  logic        out_rdy;

  logic        in_rdy_s, in_rdy_p;
  logic [31:0] onehot_s, onehot_p, map_s, map_p;
  logic        outv_s, outv_p, empty_s, empty_p, full_s, full_p, err_s, err_p;
  logic [5:0]  cnt_s, cnt_p;

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit          mBits [32];
  bit [31:0]   mOnehot;
  bit          mOutV;
  bit          mErrS;
  bit          mErrP;

  dec5_32_bitmap #(.STICKY_ERR(1'b1)) dutSticky (
    .clk(clk), .rst_n(rst_n), .in_idx(in_idx), .in_op(in_op), .in_v(in_v),
    .in_rdy(in_rdy_s), .out_onehot(onehot_s), .out_v(outv_s), .out_rdy(out_rdy),
    .map(map_s), .cnt(cnt_s), .empty(empty_s), .full(full_s), .err(err_s)
  );

  dec5_32_bitmap #(.STICKY_ERR(1'b0)) dutPulse (
    .clk(clk), .rst_n(rst_n), .in_idx(in_idx), .in_op(in_op), .in_v(in_v),
    .in_rdy(in_rdy_p), .out_onehot(onehot_p), .out_v(outv_p), .out_rdy(out_rdy),
    .map(map_p), .cnt(cnt_p), .empty(empty_p), .full(full_p), .err(err_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit [31:0] modelMap();
    bit [31:0] m = 32'd0;
    for (int i = 0; i < 32; i++) if (mBits[i]) m = m + (32'd1 << i);
    return m;
  endfunction

  function automatic int modelCnt();
    int c = 0;
    for (int i = 0; i < 32; i++) c += mBits[i];
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 32; i++) mBits[i] = 1'b0;
    mOnehot = 32'd0;
    mOutV   = 1'b0;
    mErrS   = 1'b0;
    mErrP   = 1'b0;
  endtask

  task automatic checkOutput();
    int c = modelCnt();
    check("map_s",    map_s,    modelMap());
    check("map_p",    map_p,    modelMap());
    check("cnt_s",    {26'd0, cnt_s}, c);
    check("cnt_p",    {26'd0, cnt_p}, c);
    check("empty",    {31'd0, empty_s}, (c == 0) ? 1 : 0);
    check("full",     {31'd0, full_s},  (c == 32) ? 1 : 0);
    check("onehot_s", onehot_s, mOnehot);
    check("onehot_p", onehot_p, mOnehot);
    check("out_v",    {31'd0, outv_s}, {31'd0, mOutV});
    check("err_s",    {31'd0, err_s},  {31'd0, mErrS});
    check("err_p",    {31'd0, err_p},  {31'd0, mErrP});
  endtask

  // Drive one cycle of inputs at the falling edge, step the model on the rising edge,
  // then compare at the following falling edge.
  task automatic applyStimulus(input bit v, input bit [1:0] op, input bit [4:0] idx, input bit ordy);
    bit rdy, acc, red, cur;
    in_v = v; in_op = op; in_idx = idx; out_rdy = ordy;
    rdy = !(mOutV && !ordy);
    #1;
    check("in_rdy", {31'd0, in_rdy_s}, {31'd0, rdy});
    acc = v && rdy;
    red = 1'b0;
    @(posedge clk);
    if (acc) begin
      cur = mBits[idx];
      case (op)
        2'd0: begin red = cur;         mBits[idx] = 1'b1; end
        2'd1: begin red = !cur;        mBits[idx] = 1'b0; end
        2'd2: begin                    mBits[idx] = !cur; end
        default: begin
          red = (modelCnt() == 0);
          for (int i = 0; i < 32; i++) mBits[i] = 1'b0;
        end
      endcase
      mOnehot = (op == 2'd3) ? 32'd0 : (32'd1 << idx);
      mOutV   = 1'b1;
    end else if (mOutV && ordy) begin
      mOutV = 1'b0;
    end
    mErrS = mErrS | red;
    mErrP = acc && red;
    @(negedge clk);
    checkOutput();
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput();
    check("in_rdy_rst", {31'd0, in_rdy_s}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit        v;
    bit [1:0]  op;
    bit [4:0]  idx;
    bit [31:0] expMap;
    int        expCnt;
    bit [31:0] expOnehot;
    bit        expOutV;
    bit        expErrS;
    bit        expErrP;
  } vec_t;

  vec_t vecs [6];

  initial begin
    rst_n = 1'b0; in_v = 1'b0; in_op = 2'd0; in_idx = 5'd0; out_rdy = 1'b1;
    modelReset();

    vecs[0] = '{1, 2'd0, 5'd28, 32'h10000000, 1, 32'h10000000, 1, 0, 0};
    vecs[1] = '{1, 2'd2, 5'd7,  32'h10000080, 2, 32'h00000080, 1, 0, 0};
    vecs[2] = '{1, 2'd2, 5'd7,  32'h10000000, 1, 32'h00000080, 1, 0, 0};
    vecs[3] = '{1, 2'd1, 5'd28, 32'h00000000, 0, 32'h10000000, 1, 0, 0};
    vecs[4] = '{0, 2'd0, 5'd3,  32'h00000000, 0, 32'h10000000, 0, 0, 0};
    vecs[5] = '{1, 2'd3, 5'd9,  32'h00000000, 0, 32'h00000000, 1, 1, 1};

    doReset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].v, vecs[i].op, vecs[i].idx, 1'b1);
      check("tbl_map",    map_s, vecs[i].expMap);
      check("tbl_cnt",    {26'd0, cnt_s}, vecs[i].expCnt);
      check("tbl_empty",  {31'd0, empty_s}, (vecs[i].expCnt == 0) ? 1 : 0);
      check("tbl_onehot", onehot_s, vecs[i].expOnehot);
      check("tbl_outv",   {31'd0, outv_s}, {31'd0, vecs[i].expOutV});
      check("tbl_errs",   {31'd0, err_s}, {31'd0, vecs[i].expErrS});
      check("tbl_errp",   {31'd0, err_p}, {31'd0, vecs[i].expErrP});
    end

    // Fill every bit, then one more set on the full map
    doReset();
    for (int i = 0; i < 32; i++) applyStimulus(1'b1, 2'd0, i[4:0], 1'b1);
    check("fill_map",  map_s, 32'hFFFFFFFF);
    check("fill_cnt",  {26'd0, cnt_s}, 32);
    check("fill_full", {31'd0, full_s}, 1);
    check("fill_err",  {31'd0, err_s}, 0);
    applyStimulus(1'b1, 2'd0, 5'd29, 1'b1);
    check("ovf_err", {31'd0, err_s}, 1);
    check("ovf_cnt", {26'd0, cnt_s}, 32);

    // Backpressure holds the output and blocks a pending command
    doReset();
    applyStimulus(1'b1, 2'd0, 5'd3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 2'd0, 5'd5, 1'b0);
      check("bp_rdy",    {31'd0, in_rdy_s}, 0);
      check("bp_map",    map_s, 32'h00000008);
      check("bp_onehot", onehot_s, 32'h00000008);
    end
    applyStimulus(1'b1, 2'd0, 5'd5, 1'b1);
    check("bp_release", onehot_s, 32'h00000020);
    check("bp_map2",    map_s, 32'h00000028);

    // Clear-all on a half map, then again on the empty map
    doReset();
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 2'd0, i[4:0], 1'b1);
    check("half_map", map_s, 32'h0000FFFF);
    applyStimulus(1'b1, 2'd3, 5'd0, 1'b1);
    check("clall_map",    map_s, 32'h0);
    check("clall_onehot", onehot_s, 32'h0);
    check("clall_outv",   {31'd0, outv_s}, 1);
    check("clall_err",    {31'd0, err_s}, 0);
    applyStimulus(1'b1, 2'd3, 5'd0, 1'b1);
    check("clall2_err",   {31'd0, err_s}, 1);

    // Mid-stream asynchronous reset, then a one-cycle err pulse
    doReset();
    for (int i = 8; i < 24; i++) applyStimulus(1'b1, 2'd0, i[4:0], 1'b1);
    check("mid_map", map_s, 32'h00FFFF00);
    applyStimulus(1'b1, 2'd2, 5'd8, 1'b0);
    applyStimulus(1'b1, 2'd2, 5'd8, 1'b0);
    check("mid_outv", {31'd0, outv_s}, 1);
    doReset();
    check("rst_map",  map_p, 32'h0);
    check("rst_outv", {31'd0, outv_p}, 0);
    applyStimulus(1'b1, 2'd1, 5'd4, 1'b1);
    check("pulse_hi", {31'd0, err_p}, 1);
    applyStimulus(1'b0, 2'd0, 5'd0, 1'b1);
    check("pulse_lo", {31'd0, err_p}, 0);
    check("sticky_hold", {31'd0, err_s}, 1);

    // Randomized run against the model
    doReset();
    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(0, 3) != 0,
                    ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                    5'($urandom_range(0, 31)),
                    $urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
